// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

  localparam int XLEN = 32;
  localparam int ALEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [3:0] UART_TXDATA_OFF = 4'h0;
  localparam logic [3:0] UART_STATUS_OFF = 4'h4;
  localparam logic [3:0] UART_CTRL_OFF   = 4'h8;
  localparam logic [3:0] UART_RSVD_OFF   = 4'hC;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int CTRL_EN_BIT    = 0;

  // Word index of a register byte offset, compared against dmem_addr[3:2].
  function automatic logic [1:0] reg_index(input logic [3:0] off);
    return off[3:2];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with combinational head output and an explicit occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU writes are queued and serialised on uart_tx.
//   state | meaning
//   IDLE  | line high, waiting for enable and a queued byte
//   START | start bit (low) for CLK_DIV cycles
//   DATA  | eight data bits, LSB first, CLK_DIV cycles each
//   STOP  | stop bit (high); may chain straight into the next START
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [ALEN-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int              CLK_DIV    = 868,
  parameter int              FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ALEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_we,
  input  logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            hit,
  output logic            uart_tx,
  output logic            tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV-1);

  uart_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          en_q, en_d;

  logic [1:0]      off;
  logic            wr_en, push_req, push_acc, pop;
  logic            baud_end, can_pop;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count, count_next;
  logic [7:0]      fifo_dout;
  logic [XLEN-1:0] status_word;
  logic            unused_ok;

  assign hit      = (dmem_addr[ALEN-1:4] == BASE_ADDR[ALEN-1:4]);
  assign off      = dmem_addr[3:2];
  assign wr_en    = hit & dmem_we & dmem_be[0];
  assign push_req = wr_en && (off == reg_index(UART_TXDATA_OFF));
  // Room is judged on the pre-edge count: a pop in the same cycle does not help.
  assign push_acc = push_req & ~fifo_full;

  assign unused_ok = ^{dmem_wdata[XLEN-1:8], dmem_be[3:1], dmem_addr[1:0], BASE_ADDR[3:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_acc),
    .pop   (pop),
    .din   (dmem_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    ovf_d = ovf_q;
    en_d  = en_q;
    if (wr_en && (off == reg_index(UART_STATUS_OFF)) && dmem_wdata[STAT_OVF_BIT]) ovf_d = 1'b0;
    if (push_req && fifo_full) ovf_d = 1'b1;
    if (wr_en && (off == reg_index(UART_CTRL_OFF))) en_d = dmem_wdata[CTRL_EN_BIT];
  end

  assign baud_end = (baud_q == BAUD_LAST);
  assign can_pop  = en_q & ~fifo_empty;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (can_pop) begin
          pop     = 1'b1;
          shreg_d = fifo_dout;
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          tx_d      = shreg_q[0];
          bit_idx_d = 3'd0;
          baud_d    = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (can_pop) begin
            pop     = 1'b1;
            shreg_d = fifo_dout;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign count_next = fifo_count + CW'(push_acc) - CW'(pop);
  assign busy_d     = (state_d != IDLE) | (count_next != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      en_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      en_q      <= en_d;
    end
  end

  assign uart_tx = tx_q;
  assign tx_busy = busy_q;

  always_comb begin
    status_word                            = '0;
    status_word[STAT_FULL_BIT]             = fifo_full;
    status_word[STAT_EMPTY_BIT]            = fifo_empty;
    status_word[STAT_BUSY_BIT]             = (state_q != IDLE);
    status_word[STAT_OVF_BIT]              = ovf_q;
    status_word[STAT_COUNT_LSB +: CW]      = fifo_count;
    dmem_rdata = '0;
    if (hit) begin
      if (off == reg_index(UART_STATUS_OFF)) dmem_rdata = status_word;
      else if (off == reg_index(UART_CTRL_OFF)) dmem_rdata[CTRL_EN_BIT] = en_q;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register table, directed timing sequences and random traffic vs a queue model.
module tb_mmio_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16;
  localparam int FRAME   = 10 * CLK_DIV;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_we = 1'b0;
  logic [3:0]  dmem_be = '0;
  logic [31:0] dmem_rdata;
  logic        hit, uart_tx, tx_busy;

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_be    (dmem_be),
    .dmem_rdata (dmem_rdata),
    .hit        (hit),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int wr_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: byte queue + frame position ----------------
  logic [7:0]  byte_q[$];
  int          st_log[$];
  logic        m_ovf = 1'b0, m_en = 1'b1, m_active = 1'b0, m_on = 1'b0;
  int          m_pos = 0, starts = 0, m_sz = 0;
  logic [7:0]  m_cur = '0;
  logic        m_enp, m_start;
  logic        s_rst, s_we;
  logic [31:0] s_addr, s_wd;
  logic [3:0]  s_be;

  function automatic logic exp_tx();
    if (!m_active) return 1'b1;
    if (m_pos < CLK_DIV) return 1'b0;
    if (m_pos < 9 * CLK_DIV) return m_cur[(m_pos - CLK_DIV) / CLK_DIV];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a[31:4] != BASE[31:4]) return r;
    case (a[3:2])
      2'd1: begin
        r[0]    = (byte_q.size() == DEPTH);
        r[1]    = (byte_q.size() == 0);
        r[2]    = m_active;
        r[3]    = m_ovf;
        r[12:8] = 5'(byte_q.size());
      end
      2'd2:    r[0] = m_en;
      default: r = '0;
    endcase
    return r;
  endfunction

  always begin
    @(posedge clk);
    s_rst = rst; s_addr = dmem_addr; s_wd = dmem_wdata; s_we = dmem_we; s_be = dmem_be;
    #1;
    cyc++;
    if (s_rst) begin
      byte_q.delete();
      m_ovf = 1'b0; m_en = 1'b1; m_active = 1'b0; m_pos = 0; m_on = 1'b1;
    end else if (m_on) begin
      m_sz  = byte_q.size();
      m_enp = m_en;
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) m_active = 1'b0;
      end
      m_start = !m_active && m_enp && (m_sz > 0);
      if (s_addr[31:4] == BASE[31:4] && s_we && s_be[0]) begin
        case (s_addr[3:2])
          2'd0: if (m_sz == DEPTH) m_ovf = 1'b1; else byte_q.push_back(s_wd[7:0]);
          2'd1: if (s_wd[3]) m_ovf = 1'b0;
          2'd2: m_en = s_wd[0];
          default: ;
        endcase
      end
      if (m_start) begin
        m_cur = byte_q.pop_front();
        m_active = 1'b1; m_pos = 0;
        starts++;
        st_log.push_back(cyc);
      end
    end
    if (m_on) begin
      check("uart_tx", uart_tx, exp_tx());
      check("tx_busy", tx_busy, m_active || (byte_q.size() > 0));
    end
  end

  // ---------------- bus tasks (inputs change on the falling edge) ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    dmem_addr = a; dmem_wdata = d; dmem_be = be; dmem_we = 1'b1;
    wr_edge = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dmem_we = 1'b0; dmem_be = '0;
    end
  endtask

  task automatic rd(input logic [31:0] a, input string nm, input bit use_c, input logic [31:0] c);
    @(negedge clk);
    dmem_addr = a; dmem_we = 1'b0; dmem_be = 4'hF; dmem_wdata = $urandom;
    #1;
    check({nm, ".rdata"}, dmem_rdata, m_read(a));
    check({nm, ".hit"}, hit, (a[31:4] == BASE[31:4]));
    if (use_c) check({nm, ".const"}, dmem_rdata, c);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #2;
      if (!tx_busy) break;
    end
    if (k == budget) begin
      n_vec++; n_err++;
      $display("FAIL %s: tx_busy still 1 after %0d cycles, expected 0", nm, budget);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1; dmem_we = 1'b0; dmem_be = '0;
    @(negedge clk); rst = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  vec_t tbl[23];

  initial begin
    int s0, n0;
    logic [31:0] a;
    logic [3:0]  ofs;

    tbl[0]  = '{0, 32'h8000_0004, 32'h0,         4'hF, 32'h2,   1};
    tbl[1]  = '{0, 32'h8000_0008, 32'h0,         4'hF, 32'h1,   1};
    tbl[2]  = '{0, 32'h8000_0000, 32'h0,         4'hF, 32'h0,   1};
    tbl[3]  = '{0, 32'h8000_000C, 32'h0,         4'hF, 32'h0,   1};
    tbl[4]  = '{0, 32'h8000_0010, 32'h0,         4'hF, 32'h0,   0};
    tbl[5]  = '{0, 32'h7FFF_FFF4, 32'h0,         4'hF, 32'h0,   0};
    tbl[6]  = '{0, 32'h8000_0007, 32'h0,         4'hF, 32'h2,   1};
    tbl[7]  = '{1, 32'h8000_0008, 32'h0,         4'h1, 32'h0,   1};
    tbl[8]  = '{0, 32'h8000_0008, 32'h0,         4'hF, 32'h0,   1};
    tbl[9]  = '{1, 32'h8000_0000, 32'h11,        4'h2, 32'h0,   1};
    tbl[10] = '{0, 32'h8000_0004, 32'h0,         4'hF, 32'h2,   1};
    tbl[11] = '{1, 32'h8000_0010, 32'h22,        4'hF, 32'h0,   0};
    tbl[12] = '{0, 32'h8000_0004, 32'h0,         4'hF, 32'h2,   1};
    tbl[13] = '{1, 32'h8000_0001, 32'h33,        4'h1, 32'h0,   1};
    tbl[14] = '{0, 32'h8000_0004, 32'h0,         4'hF, 32'h100, 1};
    tbl[15] = '{1, 32'h8000_000C, 32'hFFFF_FFFF, 4'hF, 32'h0,   1};
    tbl[16] = '{0, 32'h8000_000C, 32'h0,         4'hF, 32'h0,   1};
    tbl[17] = '{0, 32'h8000_0008, 32'h0,         4'hF, 32'h0,   1};
    tbl[18] = '{1, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF, 32'h0,   1};
    tbl[19] = '{0, 32'h8000_0004, 32'h0,         4'hF, 32'h100, 1};
    tbl[20] = '{1, 32'h8000_0008, 32'h1,         4'h1, 32'h0,   1};
    tbl[21] = '{0, 32'h8000_0008, 32'h0,         4'hF, 32'h1,   1};
    tbl[22] = '{0, 32'h8000_0004, 32'h0,         4'hF, 32'h6,   1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.uart_tx", uart_tx, 1'b1);
    check("reset.tx_busy", tx_busy, 1'b0);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      dmem_addr = tbl[i].addr; dmem_wdata = tbl[i].wdata;
      dmem_be = tbl[i].be; dmem_we = tbl[i].we;
      #1;
      check($sformatf("tbl[%0d].hit", i), hit, tbl[i].exp_hit);
      if (!tbl[i].we) check($sformatf("tbl[%0d].rdata", i), dmem_rdata, tbl[i].exp_rdata);
    end
    idle(1);
    wait_idle(2 * FRAME, "tbl.drain");

    // Single 0x55 frame: start bit at N+1, busy drops at N+41.
    pulse_reset();
    wr(BASE, 32'h55, 4'h1);
    n0 = wr_edge;
    idle(1);
    wait_idle(3 * FRAME, "A.drain");
    check("A.start_cycle", st_log[$], n0 + 1);
    check("A.busy_fall_cycle", cyc, n0 + 41);
    rd(BASE + 4, "A.status", 1, 32'h2);

    // Back-to-back frames, no idle gap.
    s0 = starts;
    wr(BASE, 32'hA3, 4'h1);
    wr(BASE, 32'h0F, 4'h1);
    idle(1);
    wait_idle(3 * FRAME, "B.drain");
    check("B.frames", starts - s0, 2);
    check("B.start_gap", st_log[$] - st_log[$-1], FRAME);

    // Fill with enable off, overflow, W1C, then drain 16 frames.
    wr(BASE + 8, 32'h0, 4'h1);
    for (int i = 0; i < 17; i++) wr(BASE, 32'h10 + i, 4'h1);
    idle(1);
    rd(BASE + 4, "C.status_full", 1, 32'h1009);
    wr(BASE + 4, 32'h8, 4'hF);
    idle(1);
    rd(BASE + 4, "C.status_w1c", 1, 32'h1001);
    s0 = starts;
    wr(BASE + 8, 32'h1, 4'h1);
    idle(1);
    wait_idle((DEPTH + 1) * FRAME + 50, "C.drain");
    check("C.frames", starts - s0, 16);

    // Reset in the middle of the data bits.
    wr(BASE, 32'h96, 4'h1);
    idle(15);
    check("D.mid_frame", m_active && (m_pos > CLK_DIV) && (m_pos < 9 * CLK_DIV), 1'b1);
    pulse_reset();
    #1;
    check("D.uart_tx", uart_tx, 1'b1);
    check("D.tx_busy", tx_busy, 1'b0);
    rd(BASE + 4, "D.status", 1, 32'h2);
    rd(BASE + 8, "D.ctrl", 1, 32'h1);

    // Enable cleared during the start bit: frame finishes, next byte waits.
    s0 = starts;
    wr(BASE, 32'h5A, 4'h1);
    wr(BASE, 32'hC3, 4'h1);
    wr(BASE + 8, 32'h0, 4'h1);
    idle(2 * FRAME);
    check("E.frames_disabled", starts - s0, 1);
    rd(BASE + 4, "E.status", 1, 32'h100);
    wr(BASE + 8, 32'h1, 4'h1);
    idle(1);
    wait_idle(3 * FRAME, "E.drain");
    check("E.frames_total", starts - s0, 2);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          ofs = ($urandom_range(0, 7) == 0) ? 4'($urandom) : {2'b00, 2'($urandom)};
          a   = (($urandom_range(0, 15) == 0) ? 32'h8000_0010 : BASE) + {28'h0, ofs};
          wr(a, $urandom, ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF);
        end
        5: rd(BASE + {28'h0, 4'($urandom)}, "R.read", 0, 32'h0);
        6: idle($urandom_range(1, 50));
        7: wr(BASE + 4, $urandom, 4'hF);
        8: wr(BASE + 8, {31'h0, 1'($urandom_range(0, 4) != 0)}, 4'h1);
        default: wr(BASE + 12, $urandom, 4'hF);
      endcase
    end
    wr(BASE + 8, 32'h1, 4'h1);
    idle(1);
    wait_idle((DEPTH + 2) * FRAME, "R.drain");
    rd(BASE + 4, "R.final_status", 0, 32'h0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
